// File: rtl/store_buffer.sv
// store_buffer
//   Posted-write buffer between the memory-stage store alignment logic and the
//   data-memory write port. Stores are queued in FIFO order and retired through
//   a req/ack handshake. A store to the same word as the youngest entry is
//   merged into it, but only when that entry is not the head. Loads that
//   overlap pending bytes are flagged.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   st_valid/ready    store handshake from the memory stage
//   st_addr           store byte address (bits [1:0] ignored)
//   st_byte_sel       lane-positioned byte enables
//   st_data           lane-aligned store data
//   mem_req/ack       write handshake to data memory
//   mem_addr/be/wdata head entry presented to memory
//   ld_addr           address of the load in the memory stage
//   ld_byte_sel       byte lanes the load reads
//   ld_conflict       a pending entry overlaps the load
//   empty             no pending entries
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_byte_sel,
  input  logic [31:0] st_data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_byte_sel,
  output logic        ld_conflict,
  output logic        empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [29:0]   word_q [DEPTH];
  logic [3:0]    be_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic [PW-1:0] youngest;

  logic store_ok;
  logic merge;
  logic push;
  logic pop;

  assign youngest = tail - PW'(1);
  assign st_ready = (count != (PW+1)'(DEPTH));
  assign mem_req  = (count != '0);
  assign empty    = (count == '0);

  // A store with no byte enables is dropped entirely.
  assign store_ok = st_valid && st_ready && (st_byte_sel != 4'b0000);
  // count>=2 guarantees the youngest entry is not the head, so merging never
  // alters a write that memory may be sampling.
  assign merge    = store_ok && (count >= (PW+1)'(2)) &&
                    (word_q[youngest] == st_addr[31:2]);
  assign push     = store_ok && !merge;
  assign pop      = mem_req && mem_ack;

  assign mem_addr  = {word_q[head], 2'b00};
  assign mem_wdata = data_q[head];
  assign mem_be    = mem_req ? be_q[head] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry payload needs no reset: validity is tracked by head/count only.
  always_ff @(posedge clk) begin
    if (push) begin
      word_q[tail] <= st_addr[31:2];
      be_q[tail]   <= st_byte_sel;
      data_q[tail] <= st_data;
    end else if (merge) begin
      be_q[youngest] <= be_q[youngest] | st_byte_sel;
      for (int unsigned b = 0; b < 4; b++) begin
        if (st_byte_sel[b]) data_q[youngest][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  // An entry is valid when its distance from head is below count.
  always_comb begin
    logic [PW-1:0] offs;
    ld_conflict = 1'b0;
    offs        = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - head;
      if (({1'b0, offs} < count) && (word_q[i] == ld_addr[31:2]) &&
          ((be_q[i] & ld_byte_sel) != 4'b0000)) begin
        ld_conflict = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer
//   Directed-vector bench for store_buffer (DEPTH=4). Inputs change 1 ns after
//   the rising edge; outputs are sampled there as well.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [3:0]  st_byte_sel;
  logic [31:0] st_data;
  logic        mem_req;
  logic        mem_ack;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] ld_addr;
  logic [3:0]  ld_byte_sel;
  logic        ld_conflict;
  logic        empty;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  store_buffer #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_byte_sel (st_byte_sel),
    .st_data     (st_data),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .ld_addr     (ld_addr),
    .ld_byte_sel (ld_byte_sel),
    .ld_conflict (ld_conflict),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d);
    st_valid = 1'b1; st_addr = a; st_byte_sel = be; st_data = d;
    tick();
    st_valid = 1'b0; st_byte_sel = 4'b0000;
  endtask

  task automatic ack_head(input string tag, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] d);
    check_vec({tag, "_req"},  {31'd0, mem_req}, 32'd1);
    check_vec({tag, "_addr"}, mem_addr, a);
    check_vec({tag, "_be"},   {28'd0, mem_be}, {28'd0, be});
    check_vec({tag, "_data"}, mem_wdata, d);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_byte_sel = '0;
    st_data = '0; mem_ack = 1'b0; ld_addr = '0; ld_byte_sel = '0;
    #2;
    check_vec("rst_req",   {31'd0, mem_req}, 32'd0);
    check_vec("rst_ready", {31'd0, st_ready}, 32'd1);
    check_vec("rst_empty", {31'd0, empty}, 32'd1);
    check_vec("rst_ldc",   {31'd0, ld_conflict}, 32'd0);
    check_vec("rst_be",    {28'd0, mem_be}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single store and retire
    push(32'h100, 4'b0001, 32'h0000_00AA);
    ack_head("single", 32'h100, 4'b0001, 32'h0000_00AA);
    check_vec("single_empty", {31'd0, empty}, 32'd1);

    // Ack while empty has no effect
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    check_vec("emptyack_empty", {31'd0, empty}, 32'd1);
    check_vec("emptyack_req",   {31'd0, mem_req}, 32'd0);

    // All-zero byte enables drop the store
    push(32'h500, 4'b0000, 32'hDEAD_BEEF);
    check_vec("dropbe0_empty", {31'd0, empty}, 32'd1);

    // Fill and backpressure
    for (int i = 0; i < 4; i++) push(32'(4 * i), 4'b1111, 32'hD000_0000 + 32'(i));
    check_vec("full_ready", {31'd0, st_ready}, 32'd0);
    push(32'h10, 4'b1111, 32'hBAD0_0005);
    check_vec("full_ready2", {31'd0, st_ready}, 32'd0);
    mem_ack = 1'b1;
    check_vec("full_ready_ack", {31'd0, st_ready}, 32'd0);
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ack_head($sformatf("fill%0d", i), 32'(4 * i), 4'b1111, 32'hD000_0000 + 32'(i));
      if (i == 0) check_vec("fill_ready_after_pop", {31'd0, st_ready}, 32'd1);
    end
    check_vec("fill_empty", {31'd0, empty}, 32'd1);

    // Merge into youngest (non-head) entry
    push(32'h200, 4'b0001, 32'h0000_0011);
    push(32'h300, 4'b0001, 32'h0000_0022);
    push(32'h300, 4'b1100, 32'hBBCC_0000);
    ack_head("merge0", 32'h200, 4'b0001, 32'h0000_0011);
    ack_head("merge1", 32'h300, 4'b1101, 32'hBBCC_0022);
    check_vec("merge_empty", {31'd0, empty}, 32'd1);

    // Load conflict
    push(32'h40, 4'b0011, 32'h0000_1234);
    ld_addr = 32'h40; ld_byte_sel = 4'b0100; #1;
    check_vec("ld_40_0100", {31'd0, ld_conflict}, 32'd0);
    ld_addr = 32'h42; ld_byte_sel = 4'b1100; #1;
    check_vec("ld_42_1100", {31'd0, ld_conflict}, 32'd0);
    ld_addr = 32'h40; ld_byte_sel = 4'b0010; #1;
    check_vec("ld_40_0010", {31'd0, ld_conflict}, 32'd1);
    ld_addr = 32'h44; ld_byte_sel = 4'b1111; #1;
    check_vec("ld_44_1111", {31'd0, ld_conflict}, 32'd0);
    ld_addr = 32'h40; ld_byte_sel = 4'b0010;
    ack_head("ld_drain", 32'h40, 4'b0011, 32'h0000_1234);
    check_vec("ld_after_pop", {31'd0, ld_conflict}, 32'd0);

    // Simultaneous push/pop with pointer wrap
    push(32'h1000, 4'b1111, 32'hC0DE_0000);
    push(32'h1004, 4'b1111, 32'hC0DE_0001);
    for (int k = 0; k < 10; k++) begin
      st_valid = 1'b1; st_byte_sel = 4'b1111;
      st_addr = 32'h1000 + 32'(4 * (k + 2));
      st_data = 32'hC0DE_0000 + 32'(k + 2);
      mem_ack = 1'b1;
      check_vec($sformatf("pp%0d_addr", k), mem_addr, 32'h1000 + 32'(4 * k));
      check_vec($sformatf("pp%0d_data", k), mem_wdata, 32'hC0DE_0000 + 32'(k));
      check_vec($sformatf("pp%0d_ready", k), {31'd0, st_ready}, 32'd1);
      tick();
    end
    st_valid = 1'b0; st_byte_sel = 4'b0000; mem_ack = 1'b0;
    ack_head("pp10", 32'h1028, 4'b1111, 32'hC0DE_000A);
    ack_head("pp11", 32'h102C, 4'b1111, 32'hC0DE_000B);
    check_vec("pp_empty", {31'd0, empty}, 32'd1);

    // Reset mid-transaction
    push(32'h2000, 4'b1111, 32'h1111_1111);
    push(32'h2004, 4'b1111, 32'h2222_2222);
    push(32'h2008, 4'b1111, 32'h3333_3333);
    check_vec("mid_req_before", {31'd0, mem_req}, 32'd1);
    #2; rst_n = 1'b0; #1;
    check_vec("mid_req",   {31'd0, mem_req}, 32'd0);
    check_vec("mid_empty", {31'd0, empty}, 32'd1);
    check_vec("mid_be",    {28'd0, mem_be}, 32'd0);
    tick();
    #2; rst_n = 1'b1;
    tick(); tick();
    check_vec("post_rst_req", {31'd0, mem_req}, 32'd0);
    push(32'h3000, 4'b0110, 32'h0055_6600);
    ack_head("post_rst", 32'h3000, 4'b0110, 32'h0055_6600);
    check_vec("post_rst_empty", {31'd0, empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
